mult_controller: RTL and testbench

- Control FSM for the 6x6-bit signed shift-add multiplier datapath. It sits directly upstream of the datapath and drives all of its load, shift, count and accumulate strobes.
- It sequences one multiplication per request over a start/ready/done handshake.
- It consumes the datapath's terminal-count flag (carryout) to end the iteration loop.
- It runs an independent watchdog iteration count and raises a sticky error if carryout never arrives.

---
 rtl/mult_controller_pkg.sv | 23 ++
 rtl/mult_controller.sv | 120 ++++++++++++
 tb/tb_mult_controller.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_controller_pkg.sv
// mult_controller_pkg
//   Shared constants for the shift-add multiplier controller: the 3-bit
//   state encoding and the default iteration / watchdog parameters.
//   No ports; imported by mult_controller and by anything that needs to
//   decode its state.
package mult_controller_pkg;

  // One CALC/SHIFT iteration per multiplier bit of the 6x6 datapath.
  localparam int NUM_ITER_DEFAULT   = 6;
  // Iterations tolerated beyond NUM_ITER before the watchdog fires.
  localparam int WDOG_SLACK_DEFAULT = 2;

  localparam int STATE_W = 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CALC  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

endpackage

// File: rtl/mult_controller.sv
// mult_controller
//   Moore control FSM for a 6x6-bit signed shift-add multiplier datapath.
//   Sequences one multiply per accepted start, ends the CALC/SHIFT loop on
//   the datapath's terminal-count flag, and runs its own watchdog count
//   that raises a sticky error if that flag never arrives.
//
// Ports
//   clk                in   system clock, rising edge
//   rst                in   asynchronous active-low reset
//   start              in   request level, sampled only while idle
//   carryout           in   datapath counter terminal flag (used in SHIFT)
//   ldx                out  load x and -x registers
//   ldy                out  load y register
//   shifty             out  shift y register one step
//   initcnt            out  initialise datapath counter
//   encnt              out  advance datapath counter
//   en_mult_one_bit_y  out  enable partial-product select from y bits
//   init_result        out  clear accumulator
//   ldresult           out  accumulate partial product
//   ready              out  idle, able to accept start
//   done               out  one-cycle completion pulse
//   err                out  sticky watchdog error
module mult_controller
  import mult_controller_pkg::*;
#(
  parameter int NUM_ITER   = NUM_ITER_DEFAULT,
  parameter int WDOG_SLACK = WDOG_SLACK_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic carryout,
  output logic ldx,
  output logic ldy,
  output logic shifty,
  output logic initcnt,
  output logic encnt,
  output logic en_mult_one_bit_y,
  output logic init_result,
  output logic ldresult,
  output logic ready,
  output logic done,
  output logic err
);

  localparam int ITER_MAX = NUM_ITER + WDOG_SLACK;
  localparam int CNT_W    = $clog2(ITER_MAX + 1);
  // Last SHIFT (pre-increment count) allowed before the watchdog trips.
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(ITER_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(ITER_MAX);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   iter_q, iter_d;
  logic               err_q, err_d;

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          iter_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD:  state_d = S_CALC;
      S_CALC:  state_d = S_SHIFT;
      S_SHIFT: begin
        // Saturating so a runaway loop can never wrap the watchdog.
        if (iter_q != CNT_SAT) begin
          iter_d = iter_q + CNT_W'(1);
        end
        if (carryout) begin
          state_d = S_DONE;
        end else if (iter_q == WDOG_LAST) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          state_d = S_CALC;
        end
      end
      // A start still held high must drop before another multiply begins.
      S_DONE, S_ERR: state_d = start ? S_HOLD : S_IDLE;
      S_HOLD: begin
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
    end
  end

  // Strobes decode from the registered state only.
  assign ready             = (state_q == S_IDLE);
  assign ldx               = (state_q == S_LOAD);
  assign ldy               = (state_q == S_LOAD);
  assign initcnt           = (state_q == S_LOAD);
  assign init_result       = (state_q == S_LOAD);
  assign en_mult_one_bit_y = (state_q == S_CALC);
  assign ldresult          = (state_q == S_CALC);
  assign shifty            = (state_q == S_SHIFT);
  assign encnt             = (state_q == S_SHIFT);
  assign done              = (state_q == S_DONE);
  assign err               = err_q;

endmodule

// File: tb/tb_mult_controller.sv
module tb_mult_controller;
  import mult_controller_pkg::*;

  localparam int NI = NUM_ITER_DEFAULT;
  // Cycles from the start edge (LOAD = cycle 1) to the DONE / ERR cycle.
  localparam int DONE_LAT = 2 * NI + 2;
  localparam int ERR_LAT  = 2 * (NI + WDOG_SLACK_DEFAULT) + 2;
  localparam int ERR_SHIFTS = NI + WDOG_SLACK_DEFAULT;
  localparam logic [10:0] RESET_OUTS = 11'b100_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic carryout;
  logic ldx, ldy, shifty, initcnt, encnt, en_mult_one_bit_y;
  logic init_result, ldresult, ready, done, err;
  logic force_co0 = 1'b0;

  always #5 clk = ~clk;

  mult_controller dut (
    .clk(clk), .rst(rst), .start(start), .carryout(carryout),
    .ldx(ldx), .ldy(ldy), .shifty(shifty), .initcnt(initcnt), .encnt(encnt),
    .en_mult_one_bit_y(en_mult_one_bit_y), .init_result(init_result),
    .ldresult(ldresult), .ready(ready), .done(done), .err(err)
  );

  logic [10:0] outs;
  assign outs = {ready, ldx, ldy, shifty, initcnt, encnt, en_mult_one_bit_y,
                 init_result, ldresult, done, err};

  // Behavioural radix-2 Booth datapath driven by the controller's strobes.
  logic signed [5:0]  x_in = '0, y_in = '0;
  logic signed [5:0]  xr = '0;
  logic signed [6:0]  yr = '0;
  logic        [3:0]  dp_cnt = '0;
  logic        [11:0] acc = '0;
  int                 pp_val;

  always_comb begin
    pp_val = 0;
    if (en_mult_one_bit_y) begin
      case (yr[1:0])
        2'b01:   pp_val = int'(xr) <<< dp_cnt;
        2'b10:   pp_val = -(int'(xr) <<< dp_cnt);
        default: pp_val = 0;
      endcase
    end
  end

  assign carryout = force_co0 ? 1'b0 : (dp_cnt == 4'(NI - 1));

  always @(posedge clk) begin
    if (ldx) xr <= x_in;
    if (ldy) yr <= {y_in, 1'b0};
    else if (shifty) yr <= yr >>> 1;
    if (initcnt) dp_cnt <= '0;
    else if (encnt) dp_cnt <= dp_cnt + 4'd1;
    if (init_result) acc <= '0;
    else if (ldresult) acc <= acc + 12'(pp_val);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [11:0] result;
    int          c0;
    int          xv;
    int          yv;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  // Monitor: pops the scoreboard whenever the DUT signals completion.
  bit err_prev = 1'b0;
  bit chk_ready_next = 1'b0;
  bit exp_ready_next = 1'b0;
  int shift_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      checks++;
      if ((ldx && shifty) || (ldresult && shifty) || (encnt && initcnt)) begin
        failures++;
        $display("FAIL strobe_excl cyc=%0d ldx=%b ldresult=%b shifty=%b encnt=%b initcnt=%b required no overlap",
                 cyc, ldx, ldresult, shifty, encnt, initcnt);
      end
      if (chk_ready_next) begin
        checks++;
        if (ready !== exp_ready_next) begin
          failures++;
          $display("FAIL ready_after_end got=%b required=%b", ready, exp_ready_next);
        end
        chk_ready_next = 1'b0;
      end
      if (ldx) shift_cnt = 0;
      else if (shifty) shift_cnt++;

      if (done) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL done_unexpected cyc=%0d got done=1 required done=0", cyc);
        end else begin
          e = sb.pop_front();
          if (e.is_err) begin
            failures++;
            $display("FAIL done_in_err_run got done=1 required err without done");
          end else begin
            checks++;
            if (acc !== e.result) begin
              failures++;
              $display("FAIL result x=%0d y=%0d got=%h required=%h", e.xv, e.yv, acc, e.result);
            end
            if ((cyc - e.c0 + 1) != DONE_LAT) begin
              failures++;
              $display("FAIL done_latency got=%0d required=%0d", cyc - e.c0 + 1, DONE_LAT);
            end
            $display("txn mul x=%0d y=%0d result=%h expected=%h lat=%0d",
                     e.xv, e.yv, acc, e.result, cyc - e.c0 + 1);
          end
          chk_ready_next = 1'b1;
          exp_ready_next = !start;
        end
      end

      if (err && !err_prev) begin
        checks++;
        if (sb.size() == 0 || !sb[0].is_err) begin
          failures++;
          $display("FAIL err_unexpected cyc=%0d got err=1 required err=0", cyc);
          if (sb.size() != 0) void'(sb.pop_front());
        end else begin
          e = sb.pop_front();
          checks++;
          if ((cyc - e.c0 + 1) != ERR_LAT || shift_cnt != ERR_SHIFTS) begin
            failures++;
            $display("FAIL err_timing got lat=%0d shifts=%0d required lat=%0d shifts=%0d",
                     cyc - e.c0 + 1, shift_cnt, ERR_LAT, ERR_SHIFTS);
          end
          $display("txn watchdog err lat=%0d shifts=%0d", cyc - e.c0 + 1, shift_cnt);
        end
      end
      err_prev = err;
    end else begin
      err_prev = 1'b0;
      chk_ready_next = 1'b0;
    end
  end

  task automatic wait_ready(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ready) return;
    end
    checks++;
    failures++;
    $display("FAIL ready_timeout got ready=0 for %0d cycles required ready=1", limit);
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sb.size() == 0) return;
    end
    checks++;
    failures++;
    $display("FAIL completion_timeout got pending=%0d required pending=0", sb.size());
    sb.delete();
  endtask

  task automatic issue(input int xv, input int yv, input bit is_err, input bit hold);
    exp_t e;
    wait_ready(60);
    x_in  = 6'(xv);
    y_in  = 6'(yv);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    e.is_err = is_err;
    e.result = 12'(xv * yv);
    e.c0     = cyc;
    e.xv     = xv;
    e.yv     = yv;
    sb.push_back(e);
    checks++;
    if (!(ldx && !err && !ready)) begin
      failures++;
      $display("FAIL load_after_start got ldx=%b err=%b ready=%b required ldx=1 err=0 ready=0",
               ldx, err, ready);
    end
    if (!hold) start = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== RESET_OUTS) begin
      failures++;
      $display("FAIL reset_outs got=%b required=%b", outs, RESET_OUTS);
    end
    rst = 1'b1;

    issue(5, 3, 0, 0);      wait_drain(40);
    issue(-6, 7, 0, 0);     wait_drain(40);
    issue(-32, -32, 0, 0);  wait_drain(40);

    // Start held through done: must park in HOLD, not re-trigger.
    issue(9, -4, 0, 1);
    wait_drain(40);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ready || ldx || done) begin
        failures++;
        $display("FAIL hold_blocks got ready=%b ldx=%b done=%b required all 0", ready, ldx, done);
      end
    end
    start = 1'b0;
    issue(-3, 11, 0, 0);    wait_drain(40);

    // Carryout never arrives: watchdog error, sticky until next start.
    force_co0 = 1'b1;
    issue(7, 7, 1, 0);
    wait_drain(60);
    force_co0 = 1'b0;
    wait_ready(10);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got err=%b required err=1", err);
    end
    issue(13, -2, 0, 0);    wait_drain(40);

    // Async reset in the 4th SHIFT aborts without a done pulse.
    issue(17, 5, 0, 0);
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (shifty) n++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== RESET_OUTS) begin
      failures++;
      $display("FAIL async_reset_outs got=%b required=%b", outs, RESET_OUTS);
    end
    $display("txn async reset in shift %0d outs=%b", n, outs);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    issue(1, 1, 0, 0);      wait_drain(40);

    for (int k = 0; k < 20; k++) begin
      int xv, yv;
      xv = int'($urandom_range(0, 63)) - 32;
      yv = int'($urandom_range(0, 63)) - 32;
      issue(xv, yv, 0, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      wait_drain(40);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
